// File: rtl/sysbus_line_arbiter.sv
// sysbus_line_arbiter: grants one of NCLIENT cache-line clients and runs a tagged full-line Sysbus
// read or write, byte-swapping every 64-bit beat. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module sysbus_line_arbiter #(
  parameter int NCLIENT    = 2,
  parameter int LINE_BEATS = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NCLIENT-1:0]               creq,
  input  logic [NCLIENT-1:0]               cwr,
  input  logic [NCLIENT*64-1:0]            caddr,
  input  logic [NCLIENT*64*LINE_BEATS-1:0] cwdata,
  output logic [NCLIENT-1:0]               cack,
  output logic [64*LINE_BEATS-1:0]         crdata,
  output logic [NCLIENT-1:0]               cdone,
  output logic                             reqcyc,
  output logic [63:0]                      req,
  output logic [12:0]                      reqtag,
  input  logic                             reqack,
  input  logic                             respcyc,
  input  logic [63:0]                      resp,
  input  logic [12:0]                      resptag,
  output logic                             respack
);

  localparam int LW = 64 * LINE_BEATS;
  localparam int CW = $clog2(LINE_BEATS) + 1;
  localparam int GW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam logic [3:0]    MEMORY    = 4'h1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RWAIT = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [GW-1:0]      gnt_r, gnt_s, win_s;
  logic               wr_r, wr_s;
  logic [63:0]        addr_r, addr_s;
  logic [LW-1:0]      wline_r, wline_s;
  logic [LW-1:0]      rline_r, rline_s;
  logic               grant_s, done_s, accept_s;
  logic [NCLIENT-1:0] cack_s, cdone_s;
  logic [LW-1:0]      crdata_s;
  logic               reqcyc_s;
  logic [63:0]        req_s;
  logic [12:0]        reqtag_s;
  logic               unused_s;

  function automatic logic [63:0] bswap(input logic [63:0] beat);
    logic [63:0] sw;
    for (int k = 0; k < 8; k++) begin
      sw[8*k +: 8] = beat[8*(7-k) +: 8];
    end
    return sw;
  endfunction

  function automatic logic [7:0] priv_of(input logic [GW-1:0] idx);
    return 8'd2 << idx;
  endfunction

  function automatic logic [NCLIENT-1:0] onehot(input logic [GW-1:0] idx);
    logic [NCLIENT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr_r;

  // Round-robin pick: scan downward so the nearest requester at/after the pointer wins.
  always_comb begin
    win_s = '0;
    for (int k = NCLIENT - 1; k >= 0; k--) begin
      win_s = creq[(int'(rr_ptr_r) + k) % NCLIENT] ? GW'((int'(rr_ptr_r) + k) % NCLIENT) : win_s;
    end
  end

  // Pointer moves just past each winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= '0;
    end else if (grant_s) begin
      rr_ptr_r <= (int'(win_s) == NCLIENT - 1) ? '0 : win_s + GW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority: the lowest-index requester wins.
  always_comb begin
    win_s = '0;
    for (int k = NCLIENT - 1; k >= 0; k--) begin
      win_s = creq[k] ? GW'(k) : win_s;
    end
  end
`endif

  // Only beats tagged as reads for the granted client are taken.
  assign accept_s = ((state_r == RWAIT) || (state_r == RDATA)) && respcyc &&
                    (resptag[7:0] == priv_of(gnt_r)) && !resptag[12];
  assign respack  = accept_s;
  assign unused_s = ^resptag[11:8];

  // Next-state and datapath update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    gnt_s   = gnt_r;
    wr_s    = wr_r;
    addr_s  = addr_r;
    wline_s = wline_r;
    rline_s = rline_r;
    grant_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (|creq) begin
          grant_s = 1'b1;
          gnt_s   = win_s;
          wr_s    = cwr[win_s];
          addr_s  = caddr[win_s*64 +: 64];
          wline_s = cwdata[win_s*LW +: LW];
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (reqack) begin
          cnt_s   = '0;
          state_s = wr_r ? WDATA : RWAIT;
        end else begin
          state_s = ADDR;
        end
      end
      WDATA: begin
        if (cnt_r == LAST_BEAT) begin
          cnt_s   = '0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + CW'(1);
          state_s = WDATA;
        end
      end
      RWAIT, RDATA: begin
        if (accept_s) begin
          rline_s[cnt_r*64 +: 64] = bswap(resp);
          if (cnt_r == LAST_BEAT) begin
            cnt_s   = '0;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            cnt_s   = cnt_r + CW'(1);
            state_s = RDATA;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    cack_s   = grant_s ? onehot(win_s) : '0;
    cdone_s  = done_s ? onehot(gnt_r) : '0;
    crdata_s = (done_s && !wr_r) ? rline_s : crdata;
    reqcyc_s = (state_s == ADDR) || (state_s == WDATA);
    if (state_s == ADDR) begin
      req_s = addr_s;
    end else if (state_s == WDATA) begin
      req_s = bswap(wline_s[cnt_s*64 +: 64]);
    end else begin
      req_s = '0;
    end
    reqtag_s = reqcyc_s ? {wr_s, MEMORY, priv_of(gnt_s)} : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      gnt_r   <= '0;
      wr_r    <= 1'b0;
      addr_r  <= '0;
      wline_r <= '0;
      rline_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
      wr_r    <= wr_s;
      addr_r  <= addr_s;
      wline_r <= wline_s;
      rline_r <= rline_s;
    end
  end

  // Registered client and bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cack   <= '0;
      cdone  <= '0;
      crdata <= '0;
      reqcyc <= 1'b0;
      req    <= '0;
      reqtag <= '0;
    end else begin
      cack   <= cack_s;
      cdone  <= cdone_s;
      crdata <= crdata_s;
      reqcyc <= reqcyc_s;
      req    <= req_s;
      reqtag <= reqtag_s;
    end
  end

endmodule

// File: tb/tb_sysbus_line_arbiter.sv
// Scoreboard bench for sysbus_line_arbiter: grants, completions, read lines and write beats are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_sysbus_line_arbiter;

  localparam int NC = 2;
  localparam int LB = 8;
  localparam int LW = 64 * LB;
  localparam logic [3:0] MEMORY = 4'h1;

  typedef struct {
    int            client;
    bit            rd;
    logic [LW-1:0] line;
  } done_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NC-1:0]   creq, cwr, cack, cdone;
  logic [NC*64-1:0] caddr;
  logic [NC*LW-1:0] cwdata;
  logic [LW-1:0]   crdata;
  logic            reqcyc, reqack, respcyc, respack;
  logic [63:0]     req, resp;
  logic [12:0]     reqtag, resptag;

  int          n_checks;
  int          n_errors;
  int          grant_q[$];
  done_t       done_q[$];
  logic [63:0] wbeat_q[$];

  sysbus_line_arbiter #(.NCLIENT(NC), .LINE_BEATS(LB)) dut (
    .clk(clk), .reset_n(reset_n), .creq(creq), .cwr(cwr), .caddr(caddr), .cwdata(cwdata),
    .cack(cack), .crdata(crdata), .cdone(cdone), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
    .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag), .respack(respack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] swap_bytes(input logic [63:0] x);
    return {<<8{x}};
  endfunction

  function automatic logic [LW-1:0] swap_line(input logic [LW-1:0] l);
    logic [LW-1:0] r;
    for (int b = 0; b < LB; b++) r[b*64 +: 64] = swap_bytes(l[b*64 +: 64]);
    return r;
  endfunction

  function automatic logic [LW-1:0] make_bus_line(input int seed);
    logic [LW-1:0] l;
    for (int b = 0; b < LB; b++)
      for (int j = 0; j < 8; j++) l[b*64 + 56 - 8*j +: 8] = 8'(seed*64 + 8*b + j + 1);
    return l;
  endfunction

  function automatic logic [7:0] priv_of(input int c);
    return 8'h02 << c;
  endfunction

  function automatic logic [NC-1:0] onehot(input int c);
    logic [NC-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Monitor: pop expectations as the DUT produces grants, completions and write beats.
  int          exp_g;
  done_t       exp_d;
  logic [63:0] exp_b;
  bit          wphase;
  always @(negedge clk) begin
    if (!reset_n) begin
      wphase = 1'b0;
    end else begin
      if (cack != '0) begin
        if (grant_q.size() == 0) check_val("spurious_cack", LW'(cack), '0);
        else begin
          exp_g = grant_q.pop_front();
          check_val("grant", LW'(cack), LW'(onehot(exp_g)));
        end
      end
      if (cdone != '0) begin
        if (done_q.size() == 0) check_val("spurious_cdone", LW'(cdone), '0);
        else begin
          exp_d = done_q.pop_front();
          check_val("cdone", LW'(cdone), LW'(onehot(exp_d.client)));
          if (exp_d.rd) check_val("crdata", crdata, exp_d.line);
        end
      end
      if (wphase && reqcyc) begin
        if (wbeat_q.size() == 0) check_val("spurious_wbeat", LW'(wbeat_q.size()), LW'(1));
        else begin
          exp_b = wbeat_q.pop_front();
          check_val("wbeat", LW'(req), LW'(exp_b));
        end
      end
      if (!reqcyc) wphase = 1'b0;
      else if (reqack && reqtag[12]) wphase = 1'b1;
      else wphase = wphase;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int c, input bit wr, input logic [63:0] a, input logic [LW-1:0] wl);
    int n;
    cwr[c]             = wr;
    caddr[c*64 +: 64]  = a;
    cwdata[c*LW +: LW] = wl;
    grant_q.push_back(c);
    creq[c] = 1'b1;
    n = 0;
    while (cack[c] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("cack_seen", LW'(cack[c]), LW'(1'b1));
    creq[c] = 1'b0;
  endtask

  task automatic addr_phase(input int c, input bit wr, input logic [63:0] a, input int delay);
    for (int i = 0; i <= delay; i++) begin
      check_val("addr_reqcyc", LW'(reqcyc), LW'(1'b1));
      check_val("addr_req", LW'(req), LW'(a));
      check_val("addr_reqtag", LW'(reqtag), LW'({wr, MEMORY, priv_of(c)}));
      if (i > 0) check_val("no_cack_repeat", LW'(cack), '0);
      reqack = (i == delay);
      tick();
    end
    reqack = 1'b0;
  endtask

  task automatic read_beats(input int c, input logic [LW-1:0] bl, input int nbeats,
                            input int foreign_at, input bit drop_all);
    for (int b = 0; b < nbeats; b++) begin
      if (b == foreign_at) begin
        respcyc = 1'b1;
        resp    = ~bl[b*64 +: 64];
        resptag = {1'b0, MEMORY, priv_of(c) ^ 8'h06};
        #1 check_val("foreign_respack", LW'(respack), '0);
        tick();
        resptag = {1'b1, MEMORY, priv_of(c)};
        #1 check_val("wrtag_respack", LW'(respack), '0);
        tick();
      end
      respcyc = 1'b1;
      resp    = bl[b*64 +: 64];
      resptag = {1'b0, MEMORY, priv_of(c)};
      if (b == nbeats - 1 && drop_all) creq = '0;
      #1 check_val("respack", LW'(respack), LW'(1'b1));
      tick();
    end
    respcyc = 1'b0;
    resp    = '0;
    resptag = '0;
  endtask

  task automatic read_line(input int c, input logic [63:0] a, input int seed,
                           input int foreign_at, input int delay);
    logic [LW-1:0] bl;
    done_t d;
    bl       = make_bus_line(seed);
    d.client = c;
    d.rd     = 1'b1;
    d.line   = swap_line(bl);
    done_q.push_back(d);
    request(c, 1'b0, a, '0);
    addr_phase(c, 1'b0, a, delay);
    read_beats(c, bl, LB, foreign_at, 1'b0);
    tick();
  endtask

  task automatic write_line(input int c, input logic [63:0] a, input logic [LW-1:0] wl, input int delay);
    int n;
    done_t d;
    for (int b = 0; b < LB; b++) wbeat_q.push_back(swap_bytes(wl[b*64 +: 64]));
    d.client = c;
    d.rd     = 1'b0;
    d.line   = '0;
    done_q.push_back(d);
    request(c, 1'b1, a, wl);
    addr_phase(c, 1'b1, a, delay);
    n = 0;
    while (reqcyc === 1'b1 && n < 3*LB) begin
      tick();
      n++;
    end
    check_val("wbeat_count", LW'(n), LW'(LB));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [LW-1:0] wl, bl;
  int            rr_exp[4];
  int            g, n;
  done_t         dd;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    creq = '0; cwr = '0; caddr = '0; cwdata = '0;
    reqack = 1'b0; respcyc = 1'b0; resp = '0; resptag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", LW'({cack, cdone, reqcyc, req, reqtag, respack}), '0);
    check_val("reset_crdata", crdata, '0);
    reset_n = 1'b1;
    tick();

    read_line(0, 64'h1000, 0, -1, 0);

    for (int b = 0; b < LB; b++) wl[b*64 +: 64] = {$urandom, $urandom};
    wl[63:0] = 64'h1122334455667788;
    write_line(1, 64'h2000, wl, 20);

    read_line(0, 64'h3040, 1, 2, 3);
    read_line(1, 64'hdead_beef_0000_0040, 2, 5, 1);

    // Reset in the middle of a read: no completion may follow.
    bl = make_bus_line(3);
    request(0, 1'b0, 64'h5000, '0);
    addr_phase(0, 1'b0, 64'h5000, 0);
    read_beats(0, bl, 3, -1, 1'b0);
    respcyc = 1'b1;
    resp    = bl[3*64 +: 64];
    resptag = {1'b0, MEMORY, priv_of(0)};
    reset_n = 1'b0;
    #1;
    check_val("midreset_outputs", LW'({cack, cdone, reqcyc, req, reqtag, respack}), '0);
    check_val("midreset_crdata", crdata, '0);
    respcyc = 1'b0; resp = '0; resptag = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    read_line(1, 64'h6000, 4, -1, 0);

    // Both clients requesting continuously for four lines.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      rr_exp[i] = i % 2;
`else
      rr_exp[i] = 0;
`endif
    end
    cwr = '0;
    caddr[63:0]   = 64'h8000;
    caddr[127:64] = 64'h8100;
    creq = '1;
    for (int i = 0; i < 4; i++) begin
      g  = rr_exp[i];
      bl = make_bus_line(10 + i);
      grant_q.push_back(g);
      dd.client = g;
      dd.rd     = 1'b1;
      dd.line   = swap_line(bl);
      done_q.push_back(dd);
      n = 0;
      while (cack === '0 && n < 40) begin
        tick();
        n++;
      end
      check_val("rr_cack_seen", LW'(cack != '0), LW'(1'b1));
      addr_phase(g, 1'b0, caddr[g*64 +: 64], 0);
      read_beats(g, bl, LB, -1, i == 3);
      tick();
    end
    creq = '0;

    repeat (4) tick();
    check_val("grant_q_empty", LW'(grant_q.size()), '0);
    check_val("done_q_empty", LW'(done_q.size()), '0);
    check_val("wbeat_q_empty", LW'(wbeat_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
